unix_frame_rx: RTL

Framed serial receiver for the Unix-timestamp link in the ps1_clock design. It deserialises a 32-bit Unix timestamp, sent LSB first and followed by an even-parity bit, while a frame-enable line is high. It checks framing, parity and range, then publishes the value normalised to seconds since 2020-01-01 00:00:00 UTC as a 28-bit count. Its output drives the time-of-day load path downstream.

---
 rtl/unix_frame_rx.sv | 105 ++++++++++
 1 files changed

// File: rtl/unix_frame_rx.sv
// Framed serial receiver for the Unix-timestamp link: deserialises a 32-bit LSB-first timestamp
// plus even parity, validates it and publishes seconds since 2020-01-01 as a T_WIDTH-bit count.
module unix_frame_rx #(
  parameter logic [31:0] EPOCH_OFFSET = 32'd1577836800,
  parameter int unsigned T_WIDTH      = 28
) (
  input  logic               unix_sclk,
  input  logic               reset,
  input  logic               unix_data,
  input  logic               unix_frame,
  output logic [T_WIDTH-1:0] t,
  output logic               t_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               range_err
);

  typedef enum logic [1:0] {StHunt, StIdle, StRx, StCheck} state_e;

  state_e      state;
  logic [31:0] sr;
  logic        parity;
  logic [5:0]  cnt;
  logic        overrun;

  logic [32:0] diff;
  logic        below;
  logic        above;
  logic        frame_bad;
  logic        parity_bad;

  // Range test runs in 33 bits so an underflow cannot alias into the valid window.
  always_comb begin
    diff       = {1'b0, sr} - {1'b0, EPOCH_OFFSET};
    below      = sr < EPOCH_OFFSET;
    above      = diff >= (33'd1 << T_WIDTH);
    frame_bad  = overrun || (cnt != 6'd33);
    parity_bad = (^sr) ^ parity;
  end

  always_ff @(posedge unix_sclk or posedge reset) begin
    if (reset) begin
      state      <= StHunt;
      sr         <= '0;
      parity     <= 1'b0;
      cnt        <= '0;
      overrun    <= 1'b0;
      t          <= '0;
      t_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      t_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      range_err  <= 1'b0;
      unique case (state)
        // Skip any frame already in progress when reset was released.
        StHunt: begin
          if (!unix_frame) state <= StIdle;
        end
        StIdle: begin
          cnt     <= '0;
          overrun <= 1'b0;
          if (unix_frame) begin
            sr    <= {unix_data, 31'd0};
            cnt   <= 6'd1;
            state <= StRx;
          end
        end
        StRx: begin
          if (!unix_frame) begin
            state <= StCheck;
          end else if (cnt < 6'd32) begin
            sr  <= {unix_data, sr[31:1]};
            cnt <= cnt + 6'd1;
          end else if (cnt == 6'd32) begin
            parity <= unix_data;
            cnt    <= 6'd33;
          end else begin
            overrun <= 1'b1;
          end
        end
        StCheck: begin
          state   <= StIdle;
          cnt     <= '0;
          overrun <= 1'b0;
          if (frame_bad) begin
            frame_err <= 1'b1;
          end else if (parity_bad) begin
            parity_err <= 1'b1;
          end else if (below || above) begin
            range_err <= 1'b1;
          end else begin
            t       <= diff[T_WIDTH-1:0];
            t_valid <= 1'b1;
          end
        end
        default: state <= StHunt;
      endcase
    end
  end

endmodule
